// File: rtl/mem_pkg.sv
// Shared types for the BRAM access path: access size encoding and controller FSM states.
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/load_align.sv
// Load data extraction: right-align the addressed lanes of a RAM word,
// then sign- or zero-extend to 32 bits.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  size_e       i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [31:0] w_sh;

    assign w_sh = i_word >> {i_off, 3'b000};

    always_comb begin
        o_data = w_sh;
        case (i_size)
            SIZE_B:  o_data = {{24{w_sh[7]  & ~i_unsigned}}, w_sh[7:0]};
            SIZE_H:  o_data = {{16{w_sh[15] & ~i_unsigned}}, w_sh[15:0]};
            default: o_data = w_sh;
        endcase
    end

endmodule

// File: rtl/bram_access_ctrl.sv
// Byte/half/word load-store front end for a single read-first BRAM port.
// One transaction at a time: accept -> (WAIT for loads) -> RESP until consumed.
module bram_access_ctrl
    import mem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_en,
    output logic [3:0]            mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    input  logic [31:0]           mem_dout
);

    // Byte span of the RAM; 33 bits so ADDR_WIDTH=30 still fits.
    localparam logic [32:0] LIMIT = 33'd4 << ADDR_WIDTH;

    state_e      r_state, w_next;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [1:0]  r_off;
    size_e       r_size;
    logic        r_uns;

    logic [31:0] w_offset;
    logic [31:0] w_ld;
    size_e       w_size;
    logic        w_accept;
    logic        w_err;

    assign w_size   = size_e'(req_size);
    assign w_offset = req_addr - BASE_ADDR;
    assign w_accept = req_valid && req_ready;

    always_comb begin
        w_err = ({1'b0, w_offset} >= LIMIT);
        case (w_size)
            SIZE_H:  w_err = w_err | req_addr[0];
            SIZE_W:  w_err = w_err | (req_addr[1:0] != 2'b00);
            SIZE_X:  w_err = 1'b1;
            default: ;
        endcase
    end

    // RAM port is driven straight from the request in the accept cycle.
    assign mem_en   = w_accept && !w_err;
    assign mem_addr = w_offset[ADDR_WIDTH+1:2];

    always_comb begin
        mem_wen = 4'b0000;
        if (mem_en && req_we) begin
            case (w_size)
                SIZE_B:  mem_wen = 4'b0001 << req_addr[1:0];
                SIZE_H:  mem_wen = 4'b0011 << req_addr[1:0];
                default: mem_wen = 4'b1111;
            endcase
        end
    end

    always_comb begin
        case (w_size)
            SIZE_B:  mem_din = {4{req_wdata[7:0]}};
            SIZE_H:  mem_din = {2{req_wdata[15:0]}};
            default: mem_din = req_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = (w_err || req_we) ? RESP : WAIT;
            WAIT:    w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == IDLE) && rst_n;
        rsp_valid = (r_state == RESP) && rst_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
            r_off   <= 2'b00;
            r_size  <= SIZE_B;
            r_uns   <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= 32'h0;
            r_err   <= w_err;
            r_off   <= req_addr[1:0];
            r_size  <= w_size;
            r_uns   <= req_unsigned;
        end else if (r_state == WAIT) begin
            r_rdata <= w_ld;
        end
    end

    load_align u_align (
        .i_word     (mem_dout),
        .i_off      (r_off),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_data     (w_ld)
    );

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: doc/bram_access_ctrl.md
BRAM_ACCESS_CTRL -- requirements
Module: bram_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address width of the attached RAM port (depth 2**ADDR_WIDTH 32-bit words).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address mapped to RAM word 0.
REQ-003 SHALL have port clk, input, 1, the single clock. One clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, request accepted when req_valid && req_ready.
REQ-007 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32, byte address.
REQ-009 SHALL have port req_size, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL have port req_unsigned, input, 1, zero-extend load data when 1.
REQ-011 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-012 SHALL have port rsp_valid, output, 1, response present.
REQ-013 SHALL have port rsp_ready, input, 1, response consumed when rsp_valid && rsp_ready.
REQ-014 SHALL have port rsp_rdata, output, 32, extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err, output, 1, misaligned, illegal size or out of range.
REQ-016 SHALL have RAM-side outputs mem_en (1), mem_wen (4), mem_addr (ADDR_WIDTH) and mem_din (32), plus input mem_dout (32), for a read-first RAM port with one-cycle registered read.

Function
REQ-017 SHALL implement an FSM with states IDLE, WAIT and RESP; req_ready = (state==IDLE) && rst_n.
REQ-018 SHALL in IDLE on accept: if error, leave mem_en=0 and go to RESP with rsp_err=1; else drive mem_en=1 combinationally in the accept cycle; store -> RESP, load -> WAIT.
REQ-019 SHALL flag an error when size=11, half with addr[0]=1, word with addr[1:0]!=0, or (addr-BASE_ADDR) >= 4*2**ADDR_WIDTH (unsigned compare; addresses below BASE_ADDR wrap and therefore also fail).
REQ-020 SHALL compute mem_addr = offset[ADDR_WIDTH+1:2], where offset = addr-BASE_ADDR.
REQ-021 SHALL drive mem_wen only on stores: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111. Loads SHALL drive 4'b0000.
REQ-022 SHALL build mem_din as: byte replicated into all 4 lanes; half replicated twice; word unchanged.
REQ-023 SHALL in WAIT capture mem_dout, shift it right by 8*addr[1:0] (registered at accept), sign- or zero-extend per the registered size and unsigned bit into rsp_rdata, then go to RESP.
REQ-024 SHALL in RESP assert rsp_valid and hold rsp_rdata and rsp_err stable until rsp_ready, then go to IDLE; no back-to-back accept (minimum spacing 2 cycles for stores, 3 for loads).
REQ-025 SHALL meet these latencies from the accept edge: store and error responses assert rsp_valid 1 cycle later; loads 2 cycles later.
REQ-026 SHALL hold mem_en=0 and mem_wen=0 outside the IDLE accept cycle.

Reset
REQ-027 SHALL while rst_n=0 at a clock edge force state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, and SHALL hold mem_en=0, mem_wen=0 and req_ready=0 combinationally while rst_n=0.
REQ-028 SHALL on reset mid-transaction abandon the pending response without asserting rsp_valid; a store already issued to RAM is not undone.

Structure
REQ-029 SHALL take the size enum (SIZE_B, SIZE_H, SIZE_W) and the FSM state typedef from shared package mem_pkg.
REQ-030 SHALL place load extraction and extension in combinational sub-module load_align (inputs: word, byte offset, size, unsigned; output: 32-bit result).

Verification
REQ-031 SHALL cover: SW addr 0x8 data 0xDEADBEEF -> mem_wen=F, mem_addr=2, rsp_valid 1 cycle later, rsp_err=0.
REQ-032 SHALL cover: SB addr 0x9 data 0x000000A5 -> mem_wen=0010, mem_din=0xA5A5A5A5; then LB addr 0x9 -> rsp_rdata=0xFFFFFFA5; LBU -> 0x000000A5.
REQ-033 SHALL cover: LH addr 0xA after SW 0x8=0x8001BEEF -> rsp_rdata=0xFFFF8001, rsp_valid exactly 2 cycles after accept.
REQ-034 SHALL cover: LW addr 0x6, and size=11 -> rsp_err=1, mem_en never high, rsp_rdata=0.
REQ-035 SHALL cover: default params, addr 0x1000 -> rsp_err=1; addr 0xFFC -> success, mem_addr=1023.
REQ-036 SHALL cover: rsp_ready low 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0; rst_n low in WAIT -> rsp_valid stays 0, next cycle IDLE.
